// File: rtl/k_phase_pkg.sv
// Shared phase type and rotator stage constants for k_phase_2b.
// Pulled in by the rotator and the top with import k_phase_pkg::*.
package k_phase_pkg;

  typedef logic [1:0] phase_t;

  localparam int PHASE_MAX  = 3;
  localparam int ROT_STAGE0 = 1;
  localparam int ROT_STAGE1 = 2;

endpackage

// File: rtl/rotr_2b.sv
// Combinational 2-level log rotator: rotates a word right by a 0..3 phase.
// Each level is a single 2:1 mux per bit.
module rotr_2b
  import k_phase_pkg::*;
#(
  parameter int W = 64
) (
  input  phase_t         phase,
  input  logic [W-1:0]   word,
  output logic [W-1:0]   rot
);

  logic [W-1:0] s0;
  logic [W-1:0] s0_rot;
  logic [W-1:0] s1_rot;

  assign s0_rot = {word[ROT_STAGE0-1:0], word[W-1:ROT_STAGE0]};
  assign s0     = phase[0] ? s0_rot : word;

  assign s1_rot = {s0[ROT_STAGE1-1:0], s0[W-1:ROT_STAGE1]};
  assign rot    = phase[1] ? s1_rot : s0;

endmodule

// File: rtl/k_phase_2b.sv
// Registered 2-bit phase rotator for stochastic bitstreams.
// Define K_PHASE_2B_INREG_EN to add an input register stage (latency 2).
module k_phase_2b
  import k_phase_pkg::*;
#(
  parameter int BITSTREAM = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [1:0]           k,
  input  logic [BITSTREAM-1:0] in_bits,
  output logic                 out_valid,
  output logic [BITSTREAM-1:0] out_bits
);

  logic                 s_valid;
  phase_t               s_k;
  logic [BITSTREAM-1:0] s_bits;
  logic [BITSTREAM-1:0] rot;

`ifdef K_PHASE_2B_INREG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid <= 1'b0;
      s_k     <= '0;
      s_bits  <= '0;
    end else begin
      s_valid <= in_valid;
      s_k     <= k;
      s_bits  <= in_bits;
    end
  end
`else
  assign s_valid = in_valid;
  assign s_k     = k;
  assign s_bits  = in_bits;
`endif

  rotr_2b #(
    .W(BITSTREAM)
  ) u_rotr (
    .phase(s_k),
    .word (s_bits),
    .rot  (rot)
  );

  // out_bits holds its last result while no valid word arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_bits  <= '0;
    end else begin
      out_valid <= s_valid;
      if (s_valid) out_bits <= rot;
    end
  end

endmodule

// File: tb/tb_k_phase_2b.sv
// Randomized self-checking bench for k_phase_2b (64-bit and 4-bit builds).
// Expected results come from an arithmetic rotate and a delay-line model.
module tb_k_phase_2b;
  import k_phase_pkg::*;

  localparam int W = 64;
`ifdef K_PHASE_2B_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [1:0]   k;
  logic [W-1:0] in_bits;
  logic         out_valid;
  logic [W-1:0] out_bits;

  logic         v4;
  logic [1:0]   k4;
  logic [3:0]   in4;
  logic         ov4;
  logic [3:0]   out4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         v;
    logic [W-1:0] b;
  } item_t;

  item_t        line[$];
  logic         exp_v;
  logic [W-1:0] exp_b;

  always #5 clk = ~clk;

  k_phase_2b #(.BITSTREAM(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .k        (k),
    .in_bits  (in_bits),
    .out_valid(out_valid),
    .out_bits (out_bits)
  );

  k_phase_2b #(.BITSTREAM(4)) dut4 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (v4),
    .k        (k4),
    .in_bits  (in4),
    .out_valid(ov4),
    .out_bits (out4)
  );

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x,
                                        input int n);
    if (n == 0) return x;
    return (x >> n) | (x << (W - n));
  endfunction

  task automatic check(input string tag,
                       input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    line.delete();
    for (int i = 0; i < LAT - 1; i++) line.push_back('{1'b0, '0});
    exp_v = 1'b0;
    exp_b = '0;
  endtask

  // Drive one cycle, advance the model at the edge, check at negedge.
  task automatic step(input logic v, input logic [1:0] kk,
                      input logic [W-1:0] b, input logic r);
    item_t it;
    rst      = r;
    in_valid = v;
    k        = kk;
    in_bits  = b;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      line.push_back('{v, rotr(b, int'(kk))});
      it    = line.pop_front();
      exp_v = it.v;
      if (it.v) exp_b = it.b;
    end
    @(negedge clk);
    check("out_valid", {63'd0, out_valid}, {63'd0, exp_v});
    check("out_bits", out_bits, exp_b);
  endtask

  logic [W-1:0] d_in  [4];
  logic [W-1:0] d_out [4];
  logic [W-1:0] last;

  initial begin
    d_in[0]  = 64'h0123456789ABCDEF; d_out[0] = 64'h0123456789ABCDEF;
    d_in[1]  = 64'h0000000000000001; d_out[1] = 64'h8000000000000000;
    d_in[2]  = 64'h0000000000000003; d_out[2] = 64'hC000000000000000;
    d_in[3]  = 64'h0123456789ABCDEF; d_out[3] = 64'hE02468ACF13579BD;

    rst = 1'b1; in_valid = 1'b0; k = '0; in_bits = '0;
    v4 = 1'b0; k4 = '0; in4 = '0;
    model_reset();
    @(negedge clk);

    // reset held 2 cycles with valid input present
    step(1'b1, 2'd1, {$urandom, $urandom}, 1'b1);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    step(1'b1, 2'd2, {$urandom, $urandom}, 1'b1);
    check("rst_bits", out_bits, 64'd0);
    step(1'b0, 2'd0, '0, 1'b0);
    check("post_rst_valid", {63'd0, out_valid}, 64'd0);
    check("post_rst_bits", out_bits, 64'd0);

    // directed phases
    for (int i = 0; i < 4 + LAT - 1; i++) begin
      int j;
      if (i < 4) step(1'b1, i[1:0], d_in[i], 1'b0);
      else       step(1'b0, 2'd0, '0, 1'b0);
      j = i - (LAT - 1);
      if (j >= 0) check($sformatf("dir_k%0d", j), out_bits, d_out[j]);
    end
    step(1'b0, 2'd0, '0, 1'b0);

    // sweep: back-to-back valid words, k cycling through 0..3
    for (int q = 0; q < 101; q++) begin
      step(1'b1, q[1:0], {$urandom, $urandom}, 1'b0);
      if (q >= LAT - 1) check("sweep_valid", {63'd0, out_valid}, 64'd1);
    end

    // random traffic with gaps
    for (int q = 0; q < 60; q++)
      step(1'($urandom_range(1, 0)), 2'($urandom_range(PHASE_MAX, 0)),
           {$urandom, $urandom}, 1'b0);

    // hold: one valid word, then idle
    in_bits = {$urandom, $urandom};
    last = in_bits;
    step(1'b1, 2'd3, last, 1'b0);
    for (int i = 0; i < 3 + LAT - 1; i++) step(1'b0, 2'd1, '1, 1'b0);
    check("hold_valid", {63'd0, out_valid}, 64'd0);
    check("hold_bits", out_bits, rotr(last, 3));

    // reset arriving with a valid word
    step(1'b1, 2'd1, {$urandom, $urandom}, 1'b0);
    step(1'b1, 2'd2, {$urandom, $urandom}, 1'b1);
    check("midrst_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_bits", out_bits, 64'd0);
    for (int i = 0; i < LAT + 1; i++) begin
      step(1'b0, 2'd0, '0, 1'b0);
      check("midrst_nopulse", {63'd0, out_valid}, 64'd0);
    end

    // 4-bit build: 0001 rotated right by 3
    v4 = 1'b1; k4 = 2'd3; in4 = 4'b0001;
    for (int i = 0; i < LAT; i++) begin
      step(1'b0, 2'd0, '0, 1'b0);
      v4 = 1'b0;
    end
    check("w4_valid", {63'd0, ov4}, 64'd1);
    check("w4_bits", {60'd0, out4}, 64'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
